csc_cordic_sched: RTL and testbench

- Scheduler that time-shares one CORDIC core among the three angle sources of the sparse-matrix generator: theta (s1/s2 sequence), theta1 (a0) and theta2 (a1).
- Accepts one angle triple per valid/ready handshake and issues the three angles to the shared CORDIC in fixed order: theta, theta1, theta2.
- Collects the three in-order results and presents them as one bundle (s, a0, a1) to the matrix builder with valid/ready.
- Replaces three parallel CORDIC instances with one.

---
 rtl/csc_cordic_sched.sv | 272 +++++++++++++++++++++++++++
 tb/tb_csc_cordic_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csc_cordic_sched.sv
`default_nettype none
// ============================================================================
// Module   : csc_cordic_sched
// Purpose  : Time-shares a single CORDIC core between the three angle sources
//            of the sparse-matrix generator (theta -> s, theta1 -> a0,
//            theta2 -> a1). One angle triple is accepted per handshake, the
//            three angles are issued to the CORDIC in fixed order, and the
//            three in-order results are returned to the matrix builder as one
//            bundle.
//
// Ports    : clk, rst_n                  clock, asynchronous active-low reset
//            in_theta/in_theta1/in_theta2 angle triple, in_vld/in_rdy handshake
//            cor_theta, cor_vld/cor_rdy  request channel to shared CORDIC
//            res_vld, res_ival, res_rval in-order CORDIC result channel
//            s_*, a0_*, a1_*             result bundle, out_vld/out_rdy
//            err_spur                    sticky: result with nothing pending
//            bundle_cnt, stall_cnt       statistics (CSC_SCHED_STAT_EN only)
//
// Options  : `define CSC_SCHED_STAT_EN adds bundle_cnt (wrapping count of
//            delivered bundles) and stall_cnt (saturating count of cycles a
//            request waited on cor_rdy).
//
// Revision : 1.0  initial release
// ============================================================================
module csc_cordic_sched #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_theta,
    input  logic [DATA_W-1:0] in_theta1,
    input  logic [DATA_W-1:0] in_theta2,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [DATA_W-1:0] cor_theta,
    output logic              cor_vld,
    input  logic              cor_rdy,
    input  logic              res_vld,
    input  logic [DATA_W-1:0] res_ival,
    input  logic [DATA_W-1:0] res_rval,
    output logic [DATA_W-1:0] s_ival,
    output logic [DATA_W-1:0] s_rval,
    output logic [DATA_W-1:0] a0_ival,
    output logic [DATA_W-1:0] a0_rval,
    output logic [DATA_W-1:0] a1_ival,
    output logic [DATA_W-1:0] a1_rval,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              err_spur
`ifdef CSC_SCHED_STAT_EN
   ,output logic [CNT_W-1:0]  bundle_cnt,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    // Slot indices double as issue/collect counter values.
    localparam logic [1:0] c_SLOT_S  = 2'd0;
    localparam logic [1:0] c_SLOT_A0 = 2'd1;
    localparam logic [1:0] c_SLOT_A1 = 2'd2;
    localparam logic [1:0] c_NSLOTS  = 2'd3;
    localparam logic [1:0] c_ONE2    = 2'd1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        r_iss_cnt;   // requests accepted by the CORDIC
    logic [1:0]        r_col_cnt;   // results collected
    logic [DATA_W-1:0] r_ang0;
    logic [DATA_W-1:0] r_ang1;
    logic [DATA_W-1:0] r_ang2;
    logic [DATA_W-1:0] r_s_ival;
    logic [DATA_W-1:0] r_s_rval;
    logic [DATA_W-1:0] r_a0_ival;
    logic [DATA_W-1:0] r_a0_rval;
    logic [DATA_W-1:0] r_a1_ival;
    logic [DATA_W-1:0] r_a1_rval;
    logic              r_err_spur;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic              w_in_rdy;
    logic              w_accept;
    logic              w_cor_vld;
    logic              w_issue;
    logic              w_collect;
    logic              w_last_collect;
    logic              w_spur;
    logic              w_out_vld;
    logic              w_out_hs;
    logic [DATA_W-1:0] w_cor_theta;

    // In DONE the scheduler can take a new triple in the same cycle the
    // finished bundle leaves, so a steady stream never idles a cycle.
    assign w_in_rdy  = (r_state == c_IDLE) | ((r_state == c_DONE) & out_rdy);
    assign w_accept  = in_vld & w_in_rdy;

    assign w_cor_vld = (r_state == c_RUN) & (r_iss_cnt != c_NSLOTS);
    assign w_issue   = w_cor_vld & cor_rdy;

    // A result is only legitimate if it answers a request already issued in
    // the current RUN; anything else (including stragglers from before a
    // reset) is dropped and flagged.
    assign w_collect      = res_vld & (r_state == c_RUN) & (r_col_cnt < r_iss_cnt);
    assign w_last_collect = w_collect & (r_col_cnt == c_SLOT_A1);
    assign w_spur         = res_vld & ~w_collect;

    assign w_out_vld = (r_state == c_DONE);
    assign w_out_hs  = w_out_vld & out_rdy;

    always_comb begin
        w_cor_theta = r_ang2;
        case (r_iss_cnt)
            c_SLOT_S:  w_cor_theta = r_ang0;
            c_SLOT_A0: w_cor_theta = r_ang1;
            default:   w_cor_theta = r_ang2;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (w_last_collect) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_rdy) begin
                        r_state <= in_vld ? c_RUN : c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Angle latch and issue/collect counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ang0    <= '0;
            r_ang1    <= '0;
            r_ang2    <= '0;
            r_iss_cnt <= '0;
            r_col_cnt <= '0;
        end else if (w_accept) begin
            r_ang0    <= in_theta;
            r_ang1    <= in_theta1;
            r_ang2    <= in_theta2;
            r_iss_cnt <= '0;
            r_col_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_iss_cnt <= r_iss_cnt + c_ONE2;
            end
            if (w_collect) begin
                r_col_cnt <= r_col_cnt + c_ONE2;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Result slots: written only on a legitimate collect, so they hold the
    // last bundle through DONE and IDLE regardless of spurious traffic.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_ival  <= '0;
            r_s_rval  <= '0;
            r_a0_ival <= '0;
            r_a0_rval <= '0;
            r_a1_ival <= '0;
            r_a1_rval <= '0;
        end else if (w_collect) begin
            case (r_col_cnt)
                c_SLOT_S: begin
                    r_s_ival  <= res_ival;
                    r_s_rval  <= res_rval;
                end
                c_SLOT_A0: begin
                    r_a0_ival <= res_ival;
                    r_a0_rval <= res_rval;
                end
                default: begin
                    r_a1_ival <= res_ival;
                    r_a1_rval <= res_rval;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sticky spurious-result flag (cleared only by reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_spur <= 1'b0;
        end else if (w_spur) begin
            r_err_spur <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------------
`ifdef CSC_SCHED_STAT_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_bundle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // bundle_cnt wraps naturally; stall_cnt sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bundle_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_out_hs) begin
                r_bundle_cnt <= r_bundle_cnt + c_CNT_ONE;
            end
            if (w_cor_vld && !cor_rdy && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
        end
    end

    assign bundle_cnt = r_bundle_cnt;
    assign stall_cnt  = r_stall_cnt;
`else
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_rdy    = w_in_rdy;
    assign cor_vld   = w_cor_vld;
    assign cor_theta = w_cor_theta;
    assign out_vld   = w_out_vld;
    assign s_ival    = r_s_ival;
    assign s_rval    = r_s_rval;
    assign a0_ival   = r_a0_ival;
    assign a0_rval   = r_a0_rval;
    assign a1_ival   = r_a1_ival;
    assign a1_rval   = r_a1_rval;
    assign err_spur  = r_err_spur;

endmodule
`default_nettype wire

// File: tb/tb_csc_cordic_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_csc_cordic_sched
// Purpose  : Self-checking bench for csc_cordic_sched. A transaction-level
//            model (queues of accepted triples, angles awaiting issue and
//            CORDIC results in flight) predicts every handshake signal and
//            every result word each cycle. Inputs are driven on the falling
//            edge and outputs are sampled 1 ns later.
// Revision : 1.0  initial release
// ============================================================================
module tb_csc_cordic_sched;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int LAT    = 4;    // CORDIC model latency in cycles

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] in_theta = '0, in_theta1 = '0, in_theta2 = '0;
    logic              in_vld = 1'b0;
    logic              in_rdy;
    logic [DATA_W-1:0] cor_theta;
    logic              cor_vld;
    logic              cor_rdy = 1'b0;
    logic              res_vld = 1'b0;
    logic [DATA_W-1:0] res_ival = '0, res_rval = '0;
    logic [DATA_W-1:0] s_ival, s_rval, a0_ival, a0_rval, a1_ival, a1_rval;
    logic              out_vld;
    logic              out_rdy = 1'b0;
    logic              err_spur;
`ifdef CSC_SCHED_STAT_EN
    logic [CNT_W-1:0]  bundle_cnt;
    logic [CNT_W-1:0]  stall_cnt;
`endif

    always #5 clk = ~clk;

    csc_cordic_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_theta  (in_theta),
        .in_theta1 (in_theta1),
        .in_theta2 (in_theta2),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .cor_theta (cor_theta),
        .cor_vld   (cor_vld),
        .cor_rdy   (cor_rdy),
        .res_vld   (res_vld),
        .res_ival  (res_ival),
        .res_rval  (res_rval),
        .s_ival    (s_ival),
        .s_rval    (s_rval),
        .a0_ival   (a0_ival),
        .a0_rval   (a0_rval),
        .a1_ival   (a1_ival),
        .a1_rval   (a1_rval),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .err_spur  (err_spur)
`ifdef CSC_SCHED_STAT_EN
       ,.bundle_cnt(bundle_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    typedef struct { logic [31:0] t0; logic [31:0] t1; logic [31:0] t2; } tri_t;
    typedef struct { int due; logic [31:0] iv; logic [31:0] rv; } res_t;

    tri_t        ob[$];      // accepted triples not yet delivered (at most 1)
    logic [31:0] iq[$];      // angles still waiting to be issued, in order
    res_t        cq[$];      // CORDIC results in flight
    int          rc;         // results collected for the head triple
    bit          m_spur;
    logic [31:0] m_last[6];  // last delivered bundle
    int          m_stall;
    int          m_bund;
    int          cyc;

    // Drive values applied at the next falling edge.
    bit          d_rst_n = 1'b0, d_in_vld = 1'b0, d_out_rdy = 1'b0, d_cor_rdy = 1'b0, d_spur = 1'b0;
    logic [31:0] d_th0 = '0, d_th1 = '0, d_th2 = '0;

    // Observations of the last tick.
    int          obs_cyc, last_acc_cyc;
    bit          obs_out_vld, obs_cor_hs, obs_out_hs, acc_now;

    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [31:0] fi(input logic [31:0] t);
        return t ^ 32'hC3C3_0F0F;
    endfunction

    function automatic logic [31:0] fr(input logic [31:0] t);
        return t + 32'h0001_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        ob.delete();
        iq.delete();
        rc      = 0;
        m_spur  = 1'b0;
        m_stall = 0;
        m_bund  = 0;
        for (int i = 0; i < 6; i++) m_last[i] = '0;
    endfunction

    // One clock cycle: drive, then check DUT against the model, then advance.
    task automatic tick();
        bit   e_cor_vld, e_out_vld, e_in_rdy;
        int   issued;
        tri_t h;
        @(negedge clk);
        rst_n     = d_rst_n;
        in_vld    = d_in_vld;
        in_theta  = d_th0;
        in_theta1 = d_th1;
        in_theta2 = d_th2;
        out_rdy   = d_out_rdy;
        cor_rdy   = d_cor_rdy;
        res_vld   = 1'b0;
        res_ival  = $urandom;
        res_rval  = $urandom;
        if (cq.size() > 0 && cq[0].due == cyc) begin
            res_vld  = 1'b1;
            res_ival = cq[0].iv;
            res_rval = cq[0].rv;
            void'(cq.pop_front());
        end else if (d_spur) begin
            res_vld = 1'b1;
        end
        #1;
        obs_cyc     = cyc;
        obs_out_vld = out_vld;
        obs_cor_hs  = cor_vld & cor_rdy;
        obs_out_hs  = out_vld & out_rdy;
        acc_now     = 1'b0;

        if (!rst_n) begin
            model_reset();
            chk("rst_out_vld",  {31'd0, out_vld},  32'd0);
            chk("rst_cor_vld",  {31'd0, cor_vld},  32'd0);
            chk("rst_err_spur", {31'd0, err_spur}, 32'd0);
            chk("rst_in_rdy",   {31'd0, in_rdy},   32'd1);
            chk("rst_s_ival",   s_ival,  32'd0);
            chk("rst_a1_rval",  a1_rval, 32'd0);
`ifdef CSC_SCHED_STAT_EN
            chk("rst_bundle_cnt", {16'd0, bundle_cnt}, 32'd0);
            chk("rst_stall_cnt",  {16'd0, stall_cnt},  32'd0);
`endif
            cyc++;
            return;
        end

        e_cor_vld = (iq.size() > 0);
        e_out_vld = (ob.size() > 0) && (rc == 3);
        e_in_rdy  = (ob.size() == 0) || (e_out_vld && out_rdy);
        issued    = (ob.size() > 0) ? 3 - iq.size() : 0;

        chk("cor_vld",  {31'd0, cor_vld},  {31'd0, e_cor_vld});
        chk("out_vld",  {31'd0, out_vld},  {31'd0, e_out_vld});
        chk("in_rdy",   {31'd0, in_rdy},   {31'd0, e_in_rdy});
        chk("err_spur", {31'd0, err_spur}, {31'd0, m_spur});
        if (e_cor_vld) chk("cor_theta", cor_theta, iq[0]);
        if (e_out_vld) begin
            h = ob[0];
            chk("s_ival",  s_ival,  fi(h.t0));
            chk("s_rval",  s_rval,  fr(h.t0));
            chk("a0_ival", a0_ival, fi(h.t1));
            chk("a0_rval", a0_rval, fr(h.t1));
            chk("a1_ival", a1_ival, fi(h.t2));
            chk("a1_rval", a1_rval, fr(h.t2));
        end else if (ob.size() == 0) begin
            chk("idle_s_ival",  s_ival,  m_last[0]);
            chk("idle_s_rval",  s_rval,  m_last[1]);
            chk("idle_a0_ival", a0_ival, m_last[2]);
            chk("idle_a0_rval", a0_rval, m_last[3]);
            chk("idle_a1_ival", a1_ival, m_last[4]);
            chk("idle_a1_rval", a1_rval, m_last[5]);
        end
`ifdef CSC_SCHED_STAT_EN
        chk("bundle_cnt", {16'd0, bundle_cnt}, m_bund & 32'hFFFF);
        chk("stall_cnt",  {16'd0, stall_cnt},  m_stall);
`endif

        // Model update for this cycle.
        if (res_vld) begin
            if (ob.size() > 0 && rc < issued) rc++;
            else m_spur = 1'b1;
        end
        if (e_cor_vld && !cor_rdy && m_stall < 32'hFFFF) m_stall++;
        if (e_cor_vld && cor_rdy) begin
            // The CORDIC answers whatever angle it is actually handed.
            cq.push_back('{due: cyc + LAT, iv: fi(cor_theta), rv: fr(cor_theta)});
            void'(iq.pop_front());
        end
        if (e_out_vld && out_rdy) begin
            h = ob.pop_front();
            m_last[0] = fi(h.t0); m_last[1] = fr(h.t0);
            m_last[2] = fi(h.t1); m_last[3] = fr(h.t1);
            m_last[4] = fi(h.t2); m_last[5] = fr(h.t2);
            rc = 0;
            m_bund++;
        end
        if (in_vld && e_in_rdy) begin
            ob.push_back('{t0: in_theta, t1: in_theta1, t2: in_theta2});
            iq.push_back(in_theta);
            iq.push_back(in_theta1);
            iq.push_back(in_theta2);
            rc           = 0;
            acc_now      = 1'b1;
            last_acc_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic drain();
        int k;
        d_in_vld = 1'b0;
        for (k = 0; k < 300 && (ob.size() > 0 || cq.size() > 0); k++) tick();
        if (ob.size() > 0 || cq.size() > 0) chk("drain_timeout", 32'd1, 32'd0);
        tick();
    endtask

    task automatic send(input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
        d_th0 = t0; d_th1 = t1; d_th2 = t2;
        d_in_vld = 1'b1;
        tick();
        d_in_vld = 1'b0;
        if (!acc_now) chk("send_accept", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  acc, nhs, nis, k;
        bit  found;
        int  pat[6] = '{1, 0, 0, 1, 0, 1};
`ifdef CSC_SCHED_STAT_EN
        int  s0, b0;
`endif
        cyc = 0;
        model_reset();

        // Reset state
        d_rst_n = 1'b0;
        tick(); tick();
        d_rst_n = 1'b1; d_cor_rdy = 1'b1; d_out_rdy = 1'b1;
        tick(); tick();

        // Single triple: first bundle L+4 cycles after accept
        send(32'h0001_0000, 32'h0002_0000, 32'h0003_0000);
        acc = last_acc_cyc;
        found = 1'b0;
        for (k = 0; k < 20 && !found; k++) begin
            tick();
            if (obs_out_vld) begin
                found = 1'b1;
                chk("single_latency", obs_cyc - acc, LAT + 4);
            end
        end
        if (!found) chk("single_out_vld_timeout", 32'd0, 32'd1);
        drain();

        // Output backpressure, then same-cycle handoff to a new triple
        d_out_rdy = 1'b0;
        send($urandom, $urandom, $urandom);
        found = 1'b0;
        for (k = 0; k < 30 && !found; k++) begin
            tick();
            found = obs_out_vld;
        end
        if (!found) chk("bp_out_vld_timeout", 32'd0, 32'd1);
        for (k = 0; k < 10; k++) tick();
        d_out_rdy = 1'b1;
        send($urandom, $urandom, $urandom);
        chk("bp_handoff_out_hs", {31'd0, obs_out_hs}, 32'd1);
        drain();

        // CORDIC stall pattern
        send(32'h0000_1111, 32'h0000_2222, 32'h0000_3333);
`ifdef CSC_SCHED_STAT_EN
        s0 = stall_cnt;
`endif
        nis = 0;
        for (k = 0; k < 6; k++) begin
            d_cor_rdy = pat[k][0];
            tick();
            if (obs_cor_hs) nis++;
        end
        d_cor_rdy = 1'b1;
        tick();
        chk("stall_issue_count", nis, 32'd3);
`ifdef CSC_SCHED_STAT_EN
        chk("stall_cnt_delta", stall_cnt - s0, 32'd3);
`endif
        drain();

        // Stream of 5 back-to-back triples
`ifdef CSC_SCHED_STAT_EN
        b0 = bundle_cnt;
`endif
        acc = 0; nhs = 0;
        for (k = 0; k < 300 && (acc < 5 || ob.size() > 0); k++) begin
            d_in_vld = (acc < 5);
            d_th0 = $urandom; d_th1 = $urandom; d_th2 = $urandom;
            tick();
            if (acc_now) acc++;
            if (obs_out_hs) nhs++;
        end
        d_in_vld = 1'b0;
        chk("stream_bundles", nhs, 32'd5);
`ifdef CSC_SCHED_STAT_EN
        chk("stream_bundle_cnt", (bundle_cnt - b0) & 32'hFFFF, 32'd5);
`endif
        drain();

        // Randomized traffic on all handshakes
        for (k = 0; k < 400; k++) begin
            d_in_vld  = $urandom_range(0, 1);
            d_out_rdy = ($urandom_range(0, 3) != 0);
            d_cor_rdy = ($urandom_range(0, 3) != 0);
            d_th0 = $urandom; d_th1 = $urandom; d_th2 = $urandom;
            tick();
        end
        d_out_rdy = 1'b1; d_cor_rdy = 1'b1;
        drain();

        // Spurious result while idle
        d_spur = 1'b1;
        tick();
        d_spur = 1'b0;
        tick(); tick(); tick();
        chk("spur_sticky", {31'd0, err_spur}, 32'd1);
        send($urandom, $urandom, $urandom);
        drain();
        chk("spur_still_set", {31'd0, err_spur}, 32'd1);

        // Reset after two issues; stale results must be flagged
        send(32'h0000_0AAA, 32'h0000_0BBB, 32'h0000_0CCC);
        tick(); tick();
        d_rst_n = 1'b0;
        tick();
        d_rst_n = 1'b1;
        tick();
        drain();
        chk("late_res_spur", {31'd0, err_spur}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
